// File: rtl/float_to_fix_pipe.sv
// Float-to-signed-fixed converter with selectable rounding, saturation and per-beat status flags.
// Latency: 2 cycles from input acceptance to out_valid_o (S1 decode/align, S2 round/saturate).
// Backpressure: in_ready_o = !s1 valid || S2 advancing; two beats held under full stall, no skid.
module float_to_fix_pipe #(
  parameter int EXP_WIDTH   = 5,
  parameter int MAN_WIDTH   = 10,
  parameter int FIXED_WIDTH = 40,
  parameter int FRAC_BITS   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   float_i,
  input  logic [1:0]                     round_mode_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [FIXED_WIDTH-1:0]         fixed_o,
  output logic                           nan_flag_o,
  output logic                           snan_flag_o,
  output logic                           inf_flag_o,
  output logic                           ovf_flag_o,
  output logic                           inexact_flag_o
);

  // Significand width including the hidden bit.
  localparam int SIG_W  = MAN_WIDTH + 1;
  localparam int BIAS   = (2 ** (EXP_WIDTH - 1)) - 1;
  // Left shift amount = E - SH_OFS (negative means a right shift).
  localparam int SH_OFS = BIAS + MAN_WIDTH - FRAC_BITS;
  // Right shifts beyond this all give guard 0 and sticky = |M, so clamp here.
  localparam int RCLAMP = MAN_WIDTH + 3;
  localparam int RW     = SIG_W + RCLAMP;
  localparam int LW     = SIG_W + FIXED_WIDTH;
  localparam int FW_S   = FIXED_WIDTH;

  localparam logic [FIXED_WIDTH-1:0] FIX_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
  localparam logic [FIXED_WIDTH-1:0] FIX_MIN = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

  // Aligned beat held between decode and rounding.
  typedef struct packed {
    logic                   sign;
    logic [FIXED_WIDTH-1:0] mag;     // truncated magnitude in output scaling
    logic                   guard;   // first discarded bit
    logic                   sticky;  // OR of all bits below guard
    logic                   big;     // magnitude bits above the output width
    logic                   is_inf;
    logic                   is_qnan;
    logic                   is_snan;
    logic [1:0]             rmode;
  } s1_t;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s1_load, s2_load;

  assign s2_load     = !s2_vld_q || out_ready_i;
  assign s1_load     = !s1_vld_q || s2_load;
  assign in_ready_o  = s1_load;
  assign out_valid_o = s2_vld_q;

  // Next-state of the stage valid bits.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (s1_load) s1_vld_d = in_valid_i;
    if (s2_load) s2_vld_d = s1_vld_q;
  end

  // Stage valid registers; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // ---------------------------------------------------------------------
  // S1: decode and align
  // ---------------------------------------------------------------------
  logic                     dec_sign;
  logic [EXP_WIDTH-1:0]     exp_f, exp_eff;
  logic [MAN_WIDTH-1:0]     man_f;
  logic                     normal, exp_all1;
  logic [SIG_W-1:0]         sig;
  logic signed [31:0]       shamt, nshamt;
  logic [31:0]              lsh_amt, rsh_amt;
  logic [LW-1:0]            lwide, rext, aligned;
  logic [RW-1:0]            rwide;
  s1_t                      s1_d, s1_q;

  // Split the float, build the significand and shift it into output scaling.
  always_comb begin
    dec_sign = float_i[EXP_WIDTH+MAN_WIDTH];
    exp_f    = float_i[MAN_WIDTH +: EXP_WIDTH];
    man_f    = float_i[MAN_WIDTH-1:0];
    normal   = |exp_f;
    exp_all1 = &exp_f;
    exp_eff  = normal ? exp_f : EXP_WIDTH'(1);
    sig      = {normal, man_f};

    shamt    = $signed({{(32-EXP_WIDTH){1'b0}}, exp_eff}) - SH_OFS;
    nshamt   = -shamt;

    lsh_amt  = '0;
    rsh_amt  = '0;
    if (!shamt[31]) begin
      // Anything shifted past the output width only needs to mark overflow.
      lsh_amt = (shamt > FW_S) ? 32'(FIXED_WIDTH) : shamt;
    end else begin
      rsh_amt = (nshamt > RCLAMP) ? 32'(RCLAMP) : nshamt;
    end

    lwide = {{FIXED_WIDTH{1'b0}}, sig} << lsh_amt;
    rwide = {sig, {RCLAMP{1'b0}}} >> rsh_amt;
    rext  = {{FIXED_WIDTH{1'b0}}, rwide[RW-1:RCLAMP]};

    aligned = shamt[31] ? rext : lwide;

    s1_d.sign    = dec_sign;
    s1_d.mag     = aligned[FIXED_WIDTH-1:0];
    s1_d.big     = |aligned[LW-1:FIXED_WIDTH];
    s1_d.guard   = shamt[31] ? rwide[RCLAMP-1] : 1'b0;
    s1_d.sticky  = shamt[31] ? (|rwide[RCLAMP-2:0]) : 1'b0;
    s1_d.is_inf  = exp_all1 && (man_f == '0);
    s1_d.is_qnan = exp_all1 && man_f[MAN_WIDTH-1];
    s1_d.is_snan = exp_all1 && !man_f[MAN_WIDTH-1] && (man_f != '0);
    s1_d.rmode   = round_mode_i;
  end

  // S1 payload captures an accepted beat together with its rounding mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
    end else if (s1_load && in_valid_i) begin
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------------
  // S2: round, saturate, apply sign
  // ---------------------------------------------------------------------
  logic                   inc;
  logic [FIXED_WIDTH:0]   rnd;
  logic [FIXED_WIDTH-1:0] rmag;
  logic                   pos_ovf, neg_ovf, sat;
  logic [FIXED_WIDTH-1:0] fixed_d, fixed_q;
  logic                   nan_d, snan_d, inf_d, ovf_d, inexact_d;
  logic                   nan_q, snan_q, inf_q, ovf_q, inexact_q;

  // Rounding increment on the magnitude, then range check including carry.
  always_comb begin
    case (s1_q.rmode)
      2'b01:   inc = 1'b0;
      2'b10:   inc = s1_q.sign && (s1_q.guard || s1_q.sticky);
      default: inc = s1_q.guard && (s1_q.sticky || s1_q.mag[0]);
    endcase
    rnd     = {1'b0, s1_q.mag} + {{FIXED_WIDTH{1'b0}}, inc};
    rmag    = rnd[FIXED_WIDTH-1:0];
    // Positive limit is 2^(W-1)-1; negative limit is 2^(W-1) itself.
    pos_ovf = rnd[FIXED_WIDTH] || rnd[FIXED_WIDTH-1];
    neg_ovf = rnd[FIXED_WIDTH] || (rnd[FIXED_WIDTH-1] && (|rnd[FIXED_WIDTH-2:0]));
    sat     = s1_q.big || (s1_q.sign ? neg_ovf : pos_ovf);
  end

  // Result and flag selection; specials take priority over finite handling.
  always_comb begin
    fixed_d   = '0;
    nan_d     = 1'b0;
    snan_d    = 1'b0;
    inf_d     = 1'b0;
    ovf_d     = 1'b0;
    inexact_d = 1'b0;
    if (s1_q.is_qnan) begin
      nan_d = 1'b1;
    end else if (s1_q.is_snan) begin
      snan_d = 1'b1;
    end else if (s1_q.is_inf) begin
      fixed_d = s1_q.sign ? FIX_MIN : FIX_MAX;
      inf_d   = 1'b1;
    end else if (sat) begin
      fixed_d = s1_q.sign ? FIX_MIN : FIX_MAX;
      ovf_d   = 1'b1;
    end else begin
      // Negating a zero magnitude gives zero, so -0 needs no special case.
      fixed_d   = s1_q.sign ? (~rmag + 1'b1) : rmag;
      inexact_d = s1_q.guard || s1_q.sticky;
    end
  end

  // Output registers load only when S2 advances, so they hold under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fixed_q   <= '0;
      nan_q     <= 1'b0;
      snan_q    <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else if (s2_load && s1_vld_q) begin
      fixed_q   <= fixed_d;
      nan_q     <= nan_d;
      snan_q    <= snan_d;
      inf_q     <= inf_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
    end
  end

  assign fixed_o        = fixed_q;
  assign nan_flag_o     = nan_q;
  assign snan_flag_o    = snan_q;
  assign inf_flag_o     = inf_q;
  assign ovf_flag_o     = ovf_q;
  assign inexact_flag_o = inexact_q;

endmodule

// File: tb/tb_float_to_fix_pipe.sv
// Bench for float_to_fix_pipe: half-precision input, 40-bit and 24-bit outputs, 16 fraction bits.
// Latency: checks the exact 2-cycle acceptance-to-valid timing on directed vectors.
// Backpressure: exercises full stall, random ready/valid traffic and mid-stream reset.
module tb_float_to_fix_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] float_in;
  logic [1:0]  rm;
  logic        out_ready;

  logic        in_ready40, out_valid40, nan40, snan40, inf40, ovf40, inx40;
  logic [39:0] fixed40;
  logic        in_ready24, out_valid24, nan24, snan24, inf24, ovf24, inx24;
  logic [23:0] fixed24;
  logic [4:0]  fl40, fl24;

  assign fl40 = {nan40, snan40, inf40, ovf40, inx40};
  assign fl24 = {nan24, snan24, inf24, ovf24, inx24};

  always #5 clk = ~clk;

  float_to_fix_pipe #(.EXP_WIDTH(5), .MAN_WIDTH(10), .FIXED_WIDTH(40), .FRAC_BITS(16)) u40 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready40),
    .float_i(float_in), .round_mode_i(rm), .out_valid_o(out_valid40), .out_ready_i(out_ready),
    .fixed_o(fixed40), .nan_flag_o(nan40), .snan_flag_o(snan40), .inf_flag_o(inf40),
    .ovf_flag_o(ovf40), .inexact_flag_o(inx40));

  float_to_fix_pipe #(.EXP_WIDTH(5), .MAN_WIDTH(10), .FIXED_WIDTH(24), .FRAC_BITS(16)) u24 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready24),
    .float_i(float_in), .round_mode_i(rm), .out_valid_o(out_valid24), .out_ready_i(out_ready),
    .fixed_o(fixed24), .nan_flag_o(nan24), .snan_flag_o(snan24), .inf_flag_o(inf24),
    .ovf_flag_o(ovf24), .inexact_flag_o(inx24));

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    logic [15:0] f;
    logic [1:0]  rm;
    bit          w24;
    logic [39:0] fx;
    logic [4:0]  fl;   // {nan, snan, inf, ovf, inexact}
  } vec_t;

  typedef struct {
    logic [63:0] fx40;
    logic [4:0]  fl40;
    logic [63:0] fx24;
    logic [4:0]  fl24;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact value M * 2^p, integer quotient and remainder, then rounding and limits.
  function automatic void model(input logic [15:0] f, input logic [1:0] r, input int fw,
                                output logic [63:0] fx, output logic [4:0] fl);
    bit     sgn;
    int     e, p;
    longint m, sig, q, rem, d, res, maxpos, maxneg;
    bit     inc;
    sgn    = f[15];
    e      = int'(f[14:10]);
    m      = longint'(f[9:0]);
    maxneg = longint'(1) << (fw - 1);
    maxpos = maxneg - 1;
    fl     = 5'b0;
    res    = 0;
    if (e == 31) begin
      if (m == 0) begin
        fl  = 5'b00100;
        res = sgn ? -maxneg : maxpos;
      end else begin
        fl = f[9] ? 5'b10000 : 5'b01000;
      end
    end else begin
      sig = (e == 0) ? m : m + 1024;
      p   = ((e == 0) ? 1 : e) - 15 - 10 + 16;
      if (p >= 0) begin
        q = sig << p; rem = 0; d = 1;
      end else begin
        d = longint'(1) << (-p); q = sig / d; rem = sig % d;
      end
      case (r)
        2'b01:   inc = 1'b0;
        2'b10:   inc = sgn && (rem != 0);
        default: inc = (2 * rem > d) || ((2 * rem == d) && (q % 2 == 1));
      endcase
      q = q + longint'(inc);
      if (!sgn && q > maxpos) begin
        res = maxpos; fl = 5'b00010;
      end else if (sgn && q > maxneg) begin
        res = -maxneg; fl = 5'b00010;
      end else begin
        res   = sgn ? -q : q;
        fl[0] = (rem != 0);
      end
    end
    fx = 64'(res) & ((64'd1 << fw) - 64'd1);
  endfunction

  // One clock of streaming traffic with scoreboard bookkeeping, sampled mid-cycle.
  task automatic cycle(input logic v, input logic [15:0] f, input logic [1:0] r,
                       input logic ordy, output bit acc);
    exp_t e, got;
    @(negedge clk);
    in_valid  = v;
    float_in  = f;
    rm        = r;
    out_ready = ordy;
    #1;
    acc = v && in_ready40;
    if (acc) begin
      model(f, r, 40, e.fx40, e.fl40);
      model(f, r, 24, e.fx24, e.fl24);
      sb.push_back(e);
    end
    if (out_valid40 && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got output %h, expected none", fixed40);
      end else begin
        got = sb.pop_front();
        check("stream_vld24", 64'(out_valid24), 64'd1);
        check("stream_fx40", {19'd0, fl40, fixed40}, {19'd0, got.fl40, got.fx40[39:0]});
        check("stream_fx24", {35'd0, fl24, fixed24}, {35'd0, got.fl24, got.fx24[23:0]});
      end
    end
  endtask

  // Single isolated beat with exact latency check.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    float_in  = v.f;
    rm        = v.rm;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    float_in  = 16'hFFFF;
    rm        = ~v.rm;
    check({name, "_early"}, 64'(out_valid40), 64'd0);
    @(negedge clk);
    check({name, "_vld"}, 64'(v.w24 ? out_valid24 : out_valid40), 64'd1);
    check({name, "_fx"}, v.w24 ? 64'(fixed24) : 64'(fixed40), 64'(v.fx));
    check({name, "_fl"}, 64'(v.w24 ? fl24 : fl40), 64'(v.fl));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc, hold;
    int          idx, cyc;
    logic [15:0] bp[8];
    logic [15:0] rf;
    logic [1:0]  rr;
    logic        rv;
    vec_t        post;

    vecs.push_back('{16'h3C00, 2'b00, 1'b0, 40'h00_0001_0000, 5'b00000});
    vecs.push_back('{16'hC100, 2'b00, 1'b0, 40'hFF_FFFD_8000, 5'b00000});
    vecs.push_back('{16'h0180, 2'b00, 1'b0, 40'h00_0000_0002, 5'b00001});
    vecs.push_back('{16'h0180, 2'b01, 1'b0, 40'h00_0000_0001, 5'b00001});
    vecs.push_back('{16'h0180, 2'b11, 1'b0, 40'h00_0000_0002, 5'b00001});
    vecs.push_back('{16'h8180, 2'b01, 1'b0, 40'hFF_FFFF_FFFF, 5'b00001});
    vecs.push_back('{16'h8180, 2'b10, 1'b0, 40'hFF_FFFF_FFFE, 5'b00001});
    vecs.push_back('{16'h0080, 2'b00, 1'b0, 40'h00_0000_0000, 5'b00001});
    vecs.push_back('{16'h0280, 2'b00, 1'b0, 40'h00_0000_0002, 5'b00001});
    vecs.push_back('{16'h8001, 2'b10, 1'b0, 40'hFF_FFFF_FFFF, 5'b00001});
    vecs.push_back('{16'h7BFF, 2'b00, 1'b0, 40'h00_FFE0_0000, 5'b00000});
    vecs.push_back('{16'h7C00, 2'b00, 1'b0, 40'h7F_FFFF_FFFF, 5'b00100});
    vecs.push_back('{16'hFC00, 2'b00, 1'b0, 40'h80_0000_0000, 5'b00100});
    vecs.push_back('{16'h7E00, 2'b00, 1'b0, 40'h00_0000_0000, 5'b10000});
    vecs.push_back('{16'h7C01, 2'b00, 1'b0, 40'h00_0000_0000, 5'b01000});
    vecs.push_back('{16'h0000, 2'b00, 1'b0, 40'h00_0000_0000, 5'b00000});
    vecs.push_back('{16'h8000, 2'b10, 1'b0, 40'h00_0000_0000, 5'b00000});
    vecs.push_back('{16'h7BFF, 2'b00, 1'b1, 40'h00_007F_FFFF, 5'b00010});
    vecs.push_back('{16'hFBFF, 2'b00, 1'b1, 40'h00_0080_0000, 5'b00010});
    vecs.push_back('{16'h5800, 2'b00, 1'b1, 40'h00_007F_FFFF, 5'b00010});
    vecs.push_back('{16'hD800, 2'b00, 1'b1, 40'h00_0080_0000, 5'b00000});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    float_in  = 16'h0;
    rm        = 2'b00;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid40), 64'd0);
    check("rst_fixed", 64'(fixed40), 64'd0);
    check("rst_flags", 64'(fl40), 64'd0);
    check("rst_in_ready", 64'(in_ready40), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Full back-pressure: 8 beats, out_ready low for the first 5 cycles
    bp = '{16'h3C00, 16'hC100, 16'h0180, 16'h8180, 16'h7C00, 16'h0080, 16'h4000, 16'hBC00};
    n_out = 0;
    idx   = 0;
    cyc   = 0;
    while ((idx < 8 || sb.size() != 0) && cyc < 60) begin
      cycle(idx < 8, (idx < 8) ? bp[idx] : 16'h0, 2'b00, cyc >= 5, acc);
      if (cyc == 1) check("bp_in_ready_one_held", 64'(in_ready40), 64'd1);
      if (cyc == 2 || cyc == 4) check("bp_in_ready_two_held", 64'(in_ready40), 64'd0);
      if (acc) idx++;
      cyc++;
    end
    check("bp_count", 64'(n_out), 64'd8);
    check("bp_drain", 64'(sb.size()), 64'd0);

    // Random traffic against the reference model
    hold = 1'b0;
    rf   = 16'h0;
    rr   = 2'b00;
    rv   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        rv = ($urandom_range(0, 9) < 7);
        rf = 16'($urandom);
        rr = 2'($urandom);
      end
      cycle(rv, rf, rr, ($urandom_range(0, 3) != 0), acc);
      hold = rv && !acc;
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      cycle(1'b0, 16'h0, 2'b00, 1'b1, acc);
      cyc++;
    end
    check("rand_drain", 64'(sb.size()), 64'd0);

    // Reset with two beats in flight
    cycle(1'b1, 16'h3C00, 2'b00, 1'b1, acc);
    cycle(1'b1, 16'hC100, 2'b00, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_inflight", 64'(out_valid40), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid40), 64'd0);
    check("mid_rst_fixed", 64'(fixed40), 64'd0);
    check("mid_rst_flags", 64'(fl40), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    post = '{16'h4000, 2'b00, 1'b0, 40'h00_0002_0000, 5'b00000};
    run_vec(post, "post_rst");
    @(negedge clk);
    check("post_rst_empty", 64'(out_valid40), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/float_to_fix_pipe.md
Name: float_to_fix_pipe

Overview:
Pipelined, parametrised floating-point to signed fixed-point converter with valid/ready handshakes on both sides. It succeeds the combinational float-to-fix converter and adds the following:
- any exponent/mantissa split
- configurable fractional bits in the output
- selectable rounding
- saturation on overflow
- per-beat status flags
It sits between a float-producing datapath and fixed-point accumulators, with two register stages.

Parameters:
EXP_WIDTH, 5, exponent field width (bias = 2^(EXP_WIDTH-1)-1)
MAN_WIDTH, 10, stored mantissa width (hidden bit excluded)
FIXED_WIDTH, 40, output width, two's complement
FRAC_BITS, 16, fractional bits in output (0 <= FRAC_BITS < FIXED_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input beat valid
in_ready_o  out  1  converter can accept a beat
float_i  in  1+EXP_WIDTH+MAN_WIDTH  {sign, exp, mantissa}
round_mode_i  in  2  00 RNE, 01 toward zero, 10 toward -inf, 11 treated as RNE
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
fixed_o  out  FIXED_WIDTH  converted value
nan_flag_o  out  1  quiet NaN input (exp all ones, mantissa MSB 1)
snan_flag_o  out  1  signalling NaN (exp all ones, mantissa MSB 0, other bits nonzero)
inf_flag_o  out  1  +/-inf input
ovf_flag_o  out  1  finite result saturated
inexact_flag_o  out  1  nonzero bits discarded by rounding

Behaviour:
- Reset (async assert, sync release): stage valids 0, out_valid_o 0, fixed_o 0, all flags 0. A reset mid-operation drops in-flight beats.
- Handshake: a beat transfers when valid && ready. The producer holds float_i/round_mode_i stable while in_valid_i && !in_ready_o. Outputs hold stable while out_valid_o && !out_ready_i.
- round_mode_i is sampled with its beat; changes between beats never affect beats already in flight.
- Pipeline S1 decode/align, S2 round/sign/saturate, registered outputs:
  - Latency: exactly 2 cycles from acceptance to out_valid_o, with no stall.
  - Throughput: 1 beat/cycle.
- Stage advance: S2 loads when empty or its contents are accepted. S1 loads when empty or S2 loads. in_ready_o = !s1_valid || s2 advancing (combinational from out_ready_i, no skid buffer).
- Full back-pressure holds 2 beats. There is no loss or duplication, and order is preserved.
- Decode:
  - normal = |exp; E = normal ? exp : 1; M = {normal, mantissa}.
  - Magnitude = M * 2^(E - bias - MAN_WIDTH + FRAC_BITS).
  - Shift amount is signed. For a left shift, bits beyond FIXED_WIDTH-1 set an overflow marker. For a right shift, keep guard bit and sticky (OR of the rest); shifts larger than MAN_WIDTH+2 yield guard 0 and sticky = |M.
- Rounding on magnitude:
  - RNE increments if guard && (sticky || lsb).
  - Toward zero never increments.
  - Toward -inf increments if sign && (guard || sticky).
- inexact_flag_o = guard || sticky, for finite inputs only.
- Sign: negative results are two's complement of the rounded magnitude. -0 yields 0.
- Saturation: magnitude > 2^(FIXED_WIDTH-1)-1 (positive) or > 2^(FIXED_WIDTH-1) (negative), including rounding carry. Output is 0x7F..F or 0x80..0, with ovf_flag_o=1.
- Specials (exp all ones):
  - inf gives max/min by sign, with inf_flag_o=1 and ovf_flag_o=0.
  - NaN gives fixed_o=0, with the matching nan/snan flag and other flags 0.
- Flags are mutually exclusive except inexact with ovf: a saturated result reports ovf only, with inexact 0.

Test Plan:
- Defaults, RNE, 0x3C00 (1.0) -> 0x00_0001_0000 after 2 cycles; 0xC100 (-2.5) -> 0xFF_FFFD_8000; all flags 0.
- Rounding: 0x0180 (1.5*2^-16) -> RNE 2, RTZ 1, inexact=1. Sign set (0x8180): RTZ -1 (0xFF_FFFF_FFFF), toward -inf -2. 0x0080 RNE -> 0, inexact=1.
- Specials: 0x7C00 -> 0x7F_FFFF_FFFF with inf=1. 0xFC00 -> 0x80_0000_0000 with inf=1. 0x7E00 -> 0 with nan=1. 0x7C01 -> 0 with snan=1. 0x0000/0x8000 -> 0.
- Overflow with FIXED_WIDTH=24: 0x7BFF (65504) -> 0x7FFFFF with ovf=1; 0xFBFF -> 0x800000 with ovf=1.
- Back-pressure: stream 8 beats, hold out_ready_i=0 for 5 cycles. in_ready_o drops after 2 beats are held; all 8 results emerge in order with no drop or duplication.
- Reset mid-stream: assert rst_ni low with 2 beats in flight. out_valid_o goes 0 immediately (async), outputs go 0, and the first beat after release appears 2 cycles after acceptance.
